// File: rtl/my_cpu_multicycle_control.sv
// Multicycle RISC-V control unit.
// The sequence is FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, with HALT as a
// trap state that only reset can leave.
//
// Datapath select encodings match the single-cycle control:
//   ImmSel      0=I, 1=S, 2=B, 3=J, 4=U
//   ALUSrc_B    0=rs2, 1=immediate
//   MemtoReg    0=ALU, 1=memory, 2=PC+4, 3=immediate (LUI)
//   PCOffset    1=PC feeds ALU operand A (AUIPC)
//   ALU_Control {Fun7,Fun3} style: 0000 ADD, 1000 SUB, 0010 SLT, 0011 SLTU, 1101 SRA ...
//   Branch/InverseBranch: branch taken on ALU zero, or on non-zero when inverted
//
// The datapath selects and the flags are registered. Memory and PC strobes are decoded
// from the registered state together with the live MIO_ready handshake, and they are
// forced low while rst is high.
module my_cpu_multicycle_control #(
    parameter bit SUBWORD_EN      = 1'b1,
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter int MIO_TIMEOUT     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] OPcode,
    input  logic [2:0] Fun3,
    input  logic       Fun7,
    input  logic       MIO_ready,
    output logic       CPU_MIO,
    output logic       MemRW,
    output logic [1:0] MemWidth,
    output logic       MemUnsigned,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [2:0] ImmSel,
    output logic       ALUSrc_B,
    output logic [1:0] MemtoReg,
    output logic       Jump,
    output logic       Branch,
    output logic       InverseBranch,
    output logic       PCOffset,
    output logic [3:0] ALU_Control,
    output logic       RegWrite,
    output logic       Illegal,
    output logic       Bus_error,
    output logic [2:0] State
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd7
    } state_t;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;

    localparam int CW = (MIO_TIMEOUT > 1) ? $clog2(MIO_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_LAST = (MIO_TIMEOUT > 0) ? CW'(MIO_TIMEOUT - 1) : '0;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          illegal_q, illegal_d;
    logic          bus_error_q, bus_error_d;
    logic [2:0]    imm_sel_q, imm_sel_d;
    logic          alu_src_b_q, alu_src_b_d;
    logic [1:0]    mem_to_reg_q, mem_to_reg_d;
    logic          jump_q, jump_d;
    logic          branch_q, branch_d;
    logic          inv_branch_q, inv_branch_d;
    logic          pc_offset_q, pc_offset_d;
    logic [3:0]    alu_ctrl_q, alu_ctrl_d;
    logic          is_mem_q, is_mem_d;
    logic          is_store_q, is_store_d;
    logic [1:0]    mem_width_q, mem_width_d;
    logic          mem_unsigned_q, mem_unsigned_d;

    logic          dec_legal;
    logic [2:0]    dec_imm_sel;
    logic          dec_alu_src_b;
    logic [1:0]    dec_mem_to_reg;
    logic          dec_jump;
    logic          dec_branch;
    logic          dec_inv_branch;
    logic          dec_pc_offset;
    logic [3:0]    dec_alu_ctrl;
    logic          dec_is_load;
    logic          dec_is_store;
    logic          timeout_hit;

    // Instruction decode: legality plus the single-cycle datapath selects for the opcode.
    always_comb begin
        dec_legal      = 1'b0;
        dec_imm_sel    = 3'd0;
        dec_alu_src_b  = 1'b0;
        dec_mem_to_reg = 2'd0;
        dec_jump       = 1'b0;
        dec_branch     = 1'b0;
        dec_inv_branch = 1'b0;
        dec_pc_offset  = 1'b0;
        dec_alu_ctrl   = 4'b0000;
        dec_is_load    = 1'b0;
        dec_is_store   = 1'b0;
        case (OPcode)
            OP_R: begin
                dec_legal    = 1'b1;
                dec_alu_ctrl = {Fun7, Fun3};
            end
            OP_I: begin
                dec_legal     = 1'b1;
                dec_alu_src_b = 1'b1;
                dec_alu_ctrl  = {(Fun3 == 3'b101) & Fun7, Fun3};
            end
            OP_LOAD: begin
                if (SUBWORD_EN)
                    dec_legal = !(Fun3 == 3'b011 || Fun3 == 3'b110 || Fun3 == 3'b111);
                else
                    dec_legal = (Fun3 == 3'b010);
                dec_alu_src_b  = 1'b1;
                dec_mem_to_reg = 2'd1;
                dec_is_load    = 1'b1;
            end
            OP_STORE: begin
                if (SUBWORD_EN)
                    dec_legal = (Fun3 < 3'b011);
                else
                    dec_legal = (Fun3 == 3'b010);
                dec_imm_sel   = 3'd1;
                dec_alu_src_b = 1'b1;
                dec_is_store  = 1'b1;
            end
            OP_BRANCH: begin
                dec_legal      = !(Fun3 == 3'b010 || Fun3 == 3'b011);
                dec_imm_sel    = 3'd2;
                dec_branch     = 1'b1;
                dec_inv_branch = Fun3[2] ? !Fun3[0] : Fun3[0];
                case (Fun3[2:1])
                    2'b10:   dec_alu_ctrl = 4'b0010;
                    2'b11:   dec_alu_ctrl = 4'b0011;
                    default: dec_alu_ctrl = 4'b1000;
                endcase
            end
            OP_JAL: begin
                dec_legal      = 1'b1;
                dec_imm_sel    = 3'd3;
                dec_jump       = 1'b1;
                dec_mem_to_reg = 2'd2;
            end
            OP_JALR: begin
                dec_legal      = 1'b1;
                dec_alu_src_b  = 1'b1;
                dec_jump       = 1'b1;
                dec_mem_to_reg = 2'd2;
            end
            OP_LUI: begin
                dec_legal      = 1'b1;
                dec_imm_sel    = 3'd4;
                dec_alu_src_b  = 1'b1;
                dec_mem_to_reg = 2'd3;
            end
            OP_AUIPC: begin
                dec_legal     = 1'b1;
                dec_imm_sel   = 3'd4;
                dec_alu_src_b = 1'b1;
                dec_pc_offset = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Next-state logic, wait counter, sticky flags and capture of the decoded selects.
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = '0;
        illegal_d      = illegal_q;
        bus_error_d    = bus_error_q;
        imm_sel_d      = imm_sel_q;
        alu_src_b_d    = alu_src_b_q;
        mem_to_reg_d   = mem_to_reg_q;
        jump_d         = jump_q;
        branch_d       = branch_q;
        inv_branch_d   = inv_branch_q;
        pc_offset_d    = pc_offset_q;
        alu_ctrl_d     = alu_ctrl_q;
        is_mem_d       = is_mem_q;
        is_store_d     = is_store_q;
        mem_width_d    = mem_width_q;
        mem_unsigned_d = mem_unsigned_q;
        timeout_hit    = (MIO_TIMEOUT > 0) && (wait_cnt_q == TIMEOUT_LAST);
        case (state_q)
            ST_FETCH: begin
                if (MIO_ready) begin
                    state_d = ST_DECODE;
                end else if (timeout_hit) begin
                    state_d     = ST_HALT;
                    bus_error_d = 1'b1;
                end else if (MIO_TIMEOUT > 0) begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            ST_DECODE: begin
                if (!dec_legal) begin
                    illegal_d = 1'b1;
                    if (HALT_ON_ILLEGAL)
                        state_d = ST_HALT;
                    else
                        state_d = ST_FETCH;
                end else begin
                    state_d        = ST_EXEC;
                    imm_sel_d      = dec_imm_sel;
                    alu_src_b_d    = dec_alu_src_b;
                    mem_to_reg_d   = dec_mem_to_reg;
                    jump_d         = dec_jump;
                    branch_d       = dec_branch;
                    inv_branch_d   = dec_inv_branch;
                    pc_offset_d    = dec_pc_offset;
                    alu_ctrl_d     = dec_alu_ctrl;
                    is_mem_d       = dec_is_load | dec_is_store;
                    is_store_d     = dec_is_store;
                    mem_width_d    = Fun3[1:0];
                    mem_unsigned_d = dec_is_load & Fun3[2];
                end
            end
            ST_EXEC: begin
                if (is_mem_q)
                    state_d = ST_MEM;
                else if (branch_q)
                    state_d = ST_FETCH;
                else
                    state_d = ST_WB;
            end
            ST_MEM: begin
                if (MIO_ready) begin
                    if (is_store_q)
                        state_d = ST_FETCH;
                    else
                        state_d = ST_WB;
                end else if (timeout_hit) begin
                    state_d     = ST_HALT;
                    bus_error_d = 1'b1;
                end else if (MIO_TIMEOUT > 0) begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // State, counter, flag and datapath-select registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_FETCH;
            wait_cnt_q     <= '0;
            illegal_q      <= 1'b0;
            bus_error_q    <= 1'b0;
            imm_sel_q      <= 3'd0;
            alu_src_b_q    <= 1'b0;
            mem_to_reg_q   <= 2'd0;
            jump_q         <= 1'b0;
            branch_q       <= 1'b0;
            inv_branch_q   <= 1'b0;
            pc_offset_q    <= 1'b0;
            alu_ctrl_q     <= 4'b0000;
            is_mem_q       <= 1'b0;
            is_store_q     <= 1'b0;
            mem_width_q    <= 2'd2;
            mem_unsigned_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            illegal_q      <= illegal_d;
            bus_error_q    <= bus_error_d;
            imm_sel_q      <= imm_sel_d;
            alu_src_b_q    <= alu_src_b_d;
            mem_to_reg_q   <= mem_to_reg_d;
            jump_q         <= jump_d;
            branch_q       <= branch_d;
            inv_branch_q   <= inv_branch_d;
            pc_offset_q    <= pc_offset_d;
            alu_ctrl_q     <= alu_ctrl_d;
            is_mem_q       <= is_mem_d;
            is_store_q     <= is_store_d;
            mem_width_q    <= mem_width_d;
            mem_unsigned_q <= mem_unsigned_d;
        end
    end

    // Memory and PC strobes follow the current state and handshake; reset silences them.
    always_comb begin
        CPU_MIO     = !rst && (state_q == ST_FETCH || state_q == ST_MEM);
        MemRW       = !rst && (state_q == ST_MEM) && is_store_q;
        MemWidth    = (state_q == ST_MEM) ? mem_width_q : 2'd2;
        MemUnsigned = !rst && (state_q == ST_MEM) && mem_unsigned_q;
        IRWrite     = !rst && (state_q == ST_FETCH) && MIO_ready;
        PCWrite     = !rst && ((state_q == ST_WB)
                            || (state_q == ST_MEM && MIO_ready && is_store_q)
                            || (state_q == ST_DECODE && !dec_legal && !HALT_ON_ILLEGAL));
        PCWriteCond = !rst && (state_q == ST_EXEC) && branch_q;
        RegWrite    = !rst && (state_q == ST_WB);
    end

    assign ImmSel        = imm_sel_q;
    assign ALUSrc_B      = alu_src_b_q;
    assign MemtoReg      = mem_to_reg_q;
    assign Jump          = jump_q;
    assign Branch        = branch_q;
    assign InverseBranch = inv_branch_q;
    assign PCOffset      = pc_offset_q;
    assign ALU_Control   = alu_ctrl_q;
    assign Illegal       = illegal_q;
    assign Bus_error     = bus_error_q;
    assign State         = state_q;

endmodule

// File: tb/tb_my_cpu_multicycle_control.sv
// Directed bench for the multicycle control unit.
// Three instances share one stimulus stream:
//   dut_a - default parameters
//   dut_b - only word loads and stores are legal
//   dut_c - illegal opcodes are skipped, memory waits time out after 4 cycles
module tb_my_cpu_multicycle_control;

    typedef struct packed {
        logic       cpu_mio;
        logic       mem_rw;
        logic [1:0] mem_width;
        logic       mem_unsigned;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [2:0] imm_sel;
        logic       alu_src_b;
        logic [1:0] mem_to_reg;
        logic       jump;
        logic       branch;
        logic       inverse_branch;
        logic       pc_offset;
        logic [3:0] alu_control;
        logic       reg_write;
        logic       illegal;
        logic       bus_error;
        logic [2:0] state;
    } ctrl_out_t;

    logic       clk;
    logic       rst;
    logic [4:0] opcode;
    logic [2:0] fun3;
    logic       fun7;
    logic       mio_ready;
    ctrl_out_t  out_a, out_b, out_c;

    int check_count = 0;
    int pass_count  = 0;

    my_cpu_multicycle_control dut_a (
        .clk(clk), .rst(rst), .OPcode(opcode), .Fun3(fun3), .Fun7(fun7), .MIO_ready(mio_ready),
        .CPU_MIO(out_a.cpu_mio), .MemRW(out_a.mem_rw), .MemWidth(out_a.mem_width),
        .MemUnsigned(out_a.mem_unsigned), .IRWrite(out_a.ir_write), .PCWrite(out_a.pc_write),
        .PCWriteCond(out_a.pc_write_cond), .ImmSel(out_a.imm_sel), .ALUSrc_B(out_a.alu_src_b),
        .MemtoReg(out_a.mem_to_reg), .Jump(out_a.jump), .Branch(out_a.branch),
        .InverseBranch(out_a.inverse_branch), .PCOffset(out_a.pc_offset),
        .ALU_Control(out_a.alu_control), .RegWrite(out_a.reg_write), .Illegal(out_a.illegal),
        .Bus_error(out_a.bus_error), .State(out_a.state)
    );

    my_cpu_multicycle_control #(.SUBWORD_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .OPcode(opcode), .Fun3(fun3), .Fun7(fun7), .MIO_ready(mio_ready),
        .CPU_MIO(out_b.cpu_mio), .MemRW(out_b.mem_rw), .MemWidth(out_b.mem_width),
        .MemUnsigned(out_b.mem_unsigned), .IRWrite(out_b.ir_write), .PCWrite(out_b.pc_write),
        .PCWriteCond(out_b.pc_write_cond), .ImmSel(out_b.imm_sel), .ALUSrc_B(out_b.alu_src_b),
        .MemtoReg(out_b.mem_to_reg), .Jump(out_b.jump), .Branch(out_b.branch),
        .InverseBranch(out_b.inverse_branch), .PCOffset(out_b.pc_offset),
        .ALU_Control(out_b.alu_control), .RegWrite(out_b.reg_write), .Illegal(out_b.illegal),
        .Bus_error(out_b.bus_error), .State(out_b.state)
    );

    my_cpu_multicycle_control #(.HALT_ON_ILLEGAL(1'b0), .MIO_TIMEOUT(4)) dut_c (
        .clk(clk), .rst(rst), .OPcode(opcode), .Fun3(fun3), .Fun7(fun7), .MIO_ready(mio_ready),
        .CPU_MIO(out_c.cpu_mio), .MemRW(out_c.mem_rw), .MemWidth(out_c.mem_width),
        .MemUnsigned(out_c.mem_unsigned), .IRWrite(out_c.ir_write), .PCWrite(out_c.pc_write),
        .PCWriteCond(out_c.pc_write_cond), .ImmSel(out_c.imm_sel), .ALUSrc_B(out_c.alu_src_b),
        .MemtoReg(out_c.mem_to_reg), .Jump(out_c.jump), .Branch(out_c.branch),
        .InverseBranch(out_c.inverse_branch), .PCOffset(out_c.pc_offset),
        .ALU_Control(out_c.alu_control), .RegWrite(out_c.reg_write), .Illegal(out_c.illegal),
        .Bus_error(out_c.bus_error), .State(out_c.state)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    // Drive the instruction fields and memory handshake, then let outputs settle
    task automatic applyStimulus(input logic [4:0] op, input logic [2:0] f3, input logic f7, input logic rdy);
        opcode    = op;
        fun3      = f3;
        fun7      = f7;
        mio_ready = rdy;
        #1;
    endtask

    // Advance one clock and sample just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across two edges and release it
    task automatic resetAll();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(5'b00000, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rst_state", out_a.state, 0);
        checkOutput("rst_cpu_mio", out_a.cpu_mio, 0);
        checkOutput("rst_illegal", out_a.illegal, 0);
        checkOutput("rst_bus_error", out_a.bus_error, 0);
        rst = 1'b0;
        #1;
        checkOutput("fetch_cpu_mio", out_a.cpu_mio, 1);
        checkOutput("fetch_width", out_a.mem_width, 2);
        checkOutput("fetch_rw", out_a.mem_rw, 0);

        // SUB: FETCH, DECODE, EXEC, WB
        applyStimulus(5'b01100, 3'b000, 1'b1, 1'b1);
        checkOutput("sub_f_state", out_a.state, 0);
        checkOutput("sub_f_irwrite", out_a.ir_write, 1);
        checkOutput("sub_f_regwrite", out_a.reg_write, 0);
        tick();
        checkOutput("sub_d_state", out_a.state, 1);
        checkOutput("sub_d_irwrite", out_a.ir_write, 0);
        checkOutput("sub_d_pcwrite", out_a.pc_write, 0);
        checkOutput("sub_d_cpu_mio", out_a.cpu_mio, 0);
        tick();
        checkOutput("sub_e_state", out_a.state, 2);
        checkOutput("sub_e_alu", out_a.alu_control, 4'b1000);
        checkOutput("sub_e_srcb", out_a.alu_src_b, 0);
        checkOutput("sub_e_regwrite", out_a.reg_write, 0);
        checkOutput("sub_e_pcwrite", out_a.pc_write, 0);
        tick();
        checkOutput("sub_w_state", out_a.state, 4);
        checkOutput("sub_w_regwrite", out_a.reg_write, 1);
        checkOutput("sub_w_pcwrite", out_a.pc_write, 1);
        checkOutput("sub_w_alu", out_a.alu_control, 4'b1000);
        tick();
        checkOutput("sub_done_state", out_a.state, 0);

        // LW with three wait cycles in MEM: eight cycles in total
        applyStimulus(5'b00000, 3'b010, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("lw_e_state", out_a.state, 2);
        checkOutput("lw_e_memtoreg", out_a.mem_to_reg, 1);
        checkOutput("lw_e_srcb", out_a.alu_src_b, 1);
        checkOutput("lw_e_alu", out_a.alu_control, 0);
        applyStimulus(5'b00000, 3'b010, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput("lw_m_state", out_a.state, 3);
            checkOutput("lw_m_cpu_mio", out_a.cpu_mio, 1);
            checkOutput("lw_m_rw", out_a.mem_rw, 0);
            checkOutput("lw_m_width", out_a.mem_width, 2);
            checkOutput("lw_m_regwrite", out_a.reg_write, 0);
            checkOutput("lw_m_c_state", out_c.state, 3);
            tick();
        end
        applyStimulus(5'b00000, 3'b010, 1'b0, 1'b1);
        checkOutput("lw_m4_state", out_a.state, 3);
        checkOutput("lw_m4_pcwrite", out_a.pc_write, 0);
        tick();
        checkOutput("lw_w_state", out_a.state, 4);
        checkOutput("lw_w_regwrite", out_a.reg_write, 1);
        tick();
        checkOutput("lw_done_state", out_a.state, 0);
        checkOutput("lw_c_bus_error", out_c.bus_error, 0);

        // SB: store completes in MEM on dut_a, illegal without sub-word support on dut_b
        applyStimulus(5'b01000, 3'b000, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("sb_e_state", out_a.state, 2);
        checkOutput("sb_e_immsel", out_a.imm_sel, 1);
        checkOutput("sb_b_state", out_b.state, 7);
        checkOutput("sb_b_illegal", out_b.illegal, 1);
        tick();
        checkOutput("sb_m_state", out_a.state, 3);
        checkOutput("sb_m_rw", out_a.mem_rw, 1);
        checkOutput("sb_m_width", out_a.mem_width, 0);
        checkOutput("sb_m_pcwrite", out_a.pc_write, 1);
        checkOutput("sb_m_regwrite", out_a.reg_write, 0);
        checkOutput("sb_b_cpu_mio", out_b.cpu_mio, 0);
        tick();
        checkOutput("sb_done_state", out_a.state, 0);

        // LBU: byte width, zero extension
        applyStimulus(5'b00000, 3'b100, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("lbu_m_width", out_a.mem_width, 0);
        checkOutput("lbu_m_unsigned", out_a.mem_unsigned, 1);
        tick();
        checkOutput("lbu_w_state", out_a.state, 4);
        tick();

        resetAll();

        // BNE: back to FETCH after three cycles
        applyStimulus(5'b11000, 3'b001, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("bne_e_state", out_a.state, 2);
        checkOutput("bne_e_pcwc", out_a.pc_write_cond, 1);
        checkOutput("bne_e_inv", out_a.inverse_branch, 1);
        checkOutput("bne_e_branch", out_a.branch, 1);
        checkOutput("bne_e_pcwrite", out_a.pc_write, 0);
        checkOutput("bne_e_immsel", out_a.imm_sel, 2);
        checkOutput("bne_e_alu", out_a.alu_control, 4'b1000);
        tick();
        checkOutput("bne_done_state", out_a.state, 0);
        checkOutput("bne_done_pcwc", out_a.pc_write_cond, 0);

        // SRAI: shift-right-arithmetic immediate
        applyStimulus(5'b00100, 3'b101, 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("srai_e_alu", out_a.alu_control, 4'b1101);
        checkOutput("srai_e_srcb", out_a.alu_src_b, 1);
        tick();
        checkOutput("srai_w_state", out_a.state, 4);
        tick();

        // JAL: link to PC+4 through the write-back path
        applyStimulus(5'b11011, 3'b000, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("jal_e_jump", out_a.jump, 1);
        checkOutput("jal_e_memtoreg", out_a.mem_to_reg, 2);
        checkOutput("jal_e_immsel", out_a.imm_sel, 3);
        tick();
        checkOutput("jal_w_regwrite", out_a.reg_write, 1);
        tick();

        // AUIPC: PC feeds the ALU, U-type immediate
        applyStimulus(5'b00101, 3'b000, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("auipc_e_pcoffset", out_a.pc_offset, 1);
        checkOutput("auipc_e_immsel", out_a.imm_sel, 4);
        checkOutput("auipc_e_jump", out_a.jump, 0);
        tick();
        tick();
        checkOutput("auipc_done_state", out_a.state, 0);

        // Illegal opcode: dut_a halts, dut_c skips with a PC update
        applyStimulus(5'b11111, 3'b000, 1'b0, 1'b1);
        tick();
        checkOutput("ill_d_c_pcwrite", out_c.pc_write, 1);
        checkOutput("ill_d_a_pcwrite", out_a.pc_write, 0);
        tick();
        checkOutput("ill_a_state", out_a.state, 7);
        checkOutput("ill_a_flag", out_a.illegal, 1);
        checkOutput("ill_a_cpu_mio", out_a.cpu_mio, 0);
        checkOutput("ill_c_state", out_c.state, 0);
        checkOutput("ill_c_flag", out_c.illegal, 1);
        tick();
        checkOutput("ill_a_stays", out_a.state, 7);
        checkOutput("ill_a_irwrite", out_a.ir_write, 0);

        // Branch with a reserved Fun3 is illegal
        resetAll();
        applyStimulus(5'b11000, 3'b010, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("br010_state", out_a.state, 7);

        // FETCH timeout on dut_c after four cycles without MIO_ready
        resetAll();
        checkOutput("to_a_illegal_clr", out_a.illegal, 0);
        applyStimulus(5'b01100, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("to_c_state_3", out_c.state, 0);
        checkOutput("to_c_flag_3", out_c.bus_error, 0);
        tick();
        checkOutput("to_c_state", out_c.state, 7);
        checkOutput("to_c_flag", out_c.bus_error, 1);
        checkOutput("to_c_cpu_mio", out_c.cpu_mio, 0);
        checkOutput("to_a_state", out_a.state, 0);
        checkOutput("to_a_cpu_mio", out_a.cpu_mio, 1);
        resetAll();
        checkOutput("to_rst_state", out_c.state, 0);
        checkOutput("to_rst_flag", out_c.bus_error, 0);
        checkOutput("to_rst_illegal", out_c.illegal, 0);

        // Reset during a MEM wait
        applyStimulus(5'b00000, 3'b010, 1'b0, 1'b1);
        tick();
        tick();
        applyStimulus(5'b00000, 3'b010, 1'b0, 1'b0);
        tick();
        checkOutput("mrst_pre_state", out_a.state, 3);
        checkOutput("mrst_pre_cpu_mio", out_a.cpu_mio, 1);
        rst = 1'b1;
        #1;
        checkOutput("mrst_cpu_mio", out_a.cpu_mio, 0);
        checkOutput("mrst_regwrite", out_a.reg_write, 0);
        tick();
        checkOutput("mrst_state", out_a.state, 0);
        rst = 1'b0;
        #1;
        checkOutput("mrst_fetch_cpu_mio", out_a.cpu_mio, 1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
